rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the single write port of the 8 x 16-bit dual-read register file and shares it between NREQ requesters (ALU writeback, load return, ...).
- Arbitration is round-robin with a valid/ready handshake.
- Also runs a clear sequence that writes zero to every register on demand, so software or the control unit can wipe the file without using the global reset.
- Outputs are registered and drive the register file's wr, wr_addr and d_in directly.

Parameters:
NREQ, 2, number of write requesters (2..4)
AW, 3, register address width
DW, 16, data width
NREGS, 8, number of registers (equals 2**AW)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NREQ  requester i has a write pending
req_addr  in  NREQ*AW  target register; requester i uses slice [i*AW +: AW]
req_data  in  NREQ*DW  write data; requester i uses slice [i*DW +: DW]
req_ready  out  NREQ  one-hot or zero; request i is accepted this cycle
clr_start  in  1  single-cycle pulse that requests a full clear
clr_busy  out  1  clear sequence in progress
wr  out  1  register-file write enable (registered)
wr_addr  out  AW  register-file write address (registered)
wr_data  out  DW  register-file write data (registered)

Behaviour:
- Reset (reset=0, asynchronous):
  - wr=0, wr_addr=0, wr_data=0, clr_busy=0, req_ready=0.
  - state=ARB, rr_ptr=0, clr_cnt=0.
  - Reset released mid-clear: the clear is abandoned and not resumed. Register contents are the register file's own concern.
- FSM states:
  - ARB: arbitration state.
  - CLEAR: clear sequence running.
- ARB, combinational grant:
  - Scan req_valid starting at index rr_ptr, wrapping modulo NREQ. The first valid index is the winner.
  - req_ready[winner]=1; all other bits 0.
  - req_ready depends on req_valid. Requesters must not make valid depend on ready.
  - If clr_start=1, req_ready=0 for all requesters that cycle; clear takes priority.
- ARB, transfer (valid & ready at a rising edge):
  - Register wr<=1, wr_addr<=winner addr, wr_data<=winner data.
  - rr_ptr<=(winner+1) mod NREQ.
  - The register file captures the write at the following edge, so the write is visible on read ports 2 cycles after acceptance.
- ARB, no transfer: wr<=0; wr_addr and wr_data hold their values; rr_ptr holds.
- ARB with clr_start=1: state<=CLEAR, clr_cnt<=0, wr<=0.
- CLEAR, every cycle:
  - wr<=1, wr_addr<=clr_cnt, wr_data<=0, clr_cnt<=clr_cnt+1.
  - When clr_cnt==NREGS-1, state<=ARB.
  - req_ready=0 throughout.
  - clr_busy=1 exactly while state==CLEAR, i.e. NREGS cycles.
- clr_start while in CLEAR is ignored; the sequence is not restarted or extended.
- Requesters keep valid asserted while blocked. No request is lost or reordered within a requester.
- Back-to-back grants: one write per cycle is sustained. Two requesters both valid every cycle alternate 0,1,0,1,...
- Same-address writes from different requesters in consecutive cycles land in grant order; the last grant wins.
- No arithmetic beyond modulo-NREQ pointer increment and clr_cnt wrap. clr_cnt is AW bits wide.

Decomposition:
- Shared package rf_pkg:
  - RF_AW=3, RF_DW=16, RF_NREGS=8.
  - State enum {ST_ARB, ST_CLEAR}.
- One sub-module, rr_pick: combinational round-robin winner selection.
  - Inputs: req_valid, rr_ptr.
  - Outputs: onehot grant, winner index, any_valid.
  - Reused by later arbiters (e.g. memory port sharing).

Test Plan:
1. Reset low mid-run, then high -> all outputs 0, clr_busy=0. First single request from requester 1 (addr 5, data 16'hBEEF) -> req_ready[1]=1 same cycle; next cycle wr=1, wr_addr=5, wr_data=16'hBEEF.
2. Both requesters valid continuously (req0: addr 1/data 16'h1111, req1: addr 2/data 16'h2222) -> grants 0,1,0,1. wr_addr alternates 1,2,1,2 with wr=1 every cycle.
3. clr_start pulse in cycle 0 while req0 is valid -> req_ready=0 in cycles 0-8; clr_busy=1 in cycles 1-8; wr=1 with wr_addr 0..7 and wr_data=0 in cycles 2-9. req0 is accepted in cycle 9 and its write appears in cycle 10.
4. Second clr_start pulse during CLEAR -> ignored; clr_busy still drops after exactly 8 cycles.
5. reset asserted at clear step 3 -> wr, clr_busy, wr_addr go to 0 immediately. After release, state is ARB and a request is granted with rr_ptr=0 priority (req0 wins when both are valid).
6. End to end with the register file: write 16'hA5A5 to addr 7 via req1 -> rd_addr_a=7 returns 16'hA5A5 two cycles after acceptance. After a clear, all 8 addresses read 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path: geometry of the
// 8 x 16 register file and the write-arbiter state encoding.
package rf_pkg;
    localparam int RF_AW    = 3;
    localparam int RF_DW    = 16;
    localparam int RF_NREGS = 8;

    typedef enum logic {
        ST_ARB,
        ST_CLEAR
    } state_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester, clear-control and register-file write-port signals of the
// write arbiter. The master side is the requesters; the slave side is the arbiter.
interface rf_write_arbiter_if
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               clr_start;
    logic               clr_busy;
    logic               wr;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;

    modport master (
        output req_valid, req_addr, req_data, clr_start,
        input  req_ready, clr_busy, wr, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_start,
        output req_ready, clr_busy, wr, wr_addr, wr_data
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid index at or after ptr,
// wrapping modulo NREQ. Purely combinational so it can be reused by other arbiters.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   winner,
    output logic            any_valid
);
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        // Indices at or above ptr come first; the second pass covers the wrap.
        for (int i = 0; i < NREQ; i++) begin
            if (!any_valid && valid[i] && (PW'(i) >= ptr)) begin
                any_valid = 1'b1;
                winner    = PW'(i);
                grant[i]  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any_valid && valid[i] && (PW'(i) < ptr)) begin
                any_valid = 1'b1;
                winner    = PW'(i);
                grant[i]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: round-robin sharing between NREQ
// requesters plus an on-demand sequence that writes zero to every register.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW,
    parameter int NREGS = RF_NREGS
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nx;
    logic [PW-1:0]   rr_ptr, rr_ptr_nx, winner;
    logic [AW-1:0]   clr_cnt, clr_cnt_nx;
    logic [AW-1:0]   wr_addr_q, wr_addr_nx, sel_addr;
    logic [DW-1:0]   wr_data_q, wr_data_nx, sel_data;
    logic            wr_q, wr_nx, any_valid;
    logic [NREQ-1:0] grant;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .valid     (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = bus.req_addr[i*AW +: AW];
                sel_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_nx   = state;
        rr_ptr_nx  = rr_ptr;
        clr_cnt_nx = clr_cnt;
        wr_nx      = 1'b0;
        wr_addr_nx = wr_addr_q;
        wr_data_nx = wr_data_q;
        case (state)
            ST_ARB: begin
                // A clear request pre-empts any grant in the same cycle.
                if (bus.clr_start) begin
                    state_nx   = ST_CLEAR;
                    clr_cnt_nx = '0;
                end else if (any_valid) begin
                    wr_nx      = 1'b1;
                    wr_addr_nx = sel_addr;
                    wr_data_nx = sel_data;
                    rr_ptr_nx  = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
                end
            end
            ST_CLEAR: begin
                wr_nx      = 1'b1;
                wr_addr_nx = clr_cnt;
                wr_data_nx = '0;
                clr_cnt_nx = clr_cnt + AW'(1);
                if (clr_cnt == AW'(NREGS - 1)) begin
                    state_nx = ST_ARB;
                end
            end
            default: state_nx = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_ARB;
            rr_ptr    <= '0;
            clr_cnt   <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            clr_cnt   <= clr_cnt_nx;
            wr_q      <= wr_nx;
            wr_addr_q <= wr_addr_nx;
            wr_data_q <= wr_data_nx;
        end
    end

    assign bus.req_ready = ((state == ST_ARB) && !bus.clr_start) ? grant : '0;
    assign bus.clr_busy  = (state == ST_CLEAR);
    assign bus.wr        = wr_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: per-cycle handshake checks plus a
// write-stream scoreboard and a behavioural register file for read-back.
module tb_rf_write_arbiter;
    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic reset;
    int   total;
    int   passed;
    int   failed;
    wr_t  sb[$];
    wr_t  e;

    logic [15:0] rf [8];
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_a;

    rf_write_arbiter_if #(.NREQ(2), .AW(3), .DW(16)) bus ();

    rf_write_arbiter #(.NREQ(2), .AW(3), .DW(16), .NREGS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the arbiter: captures at the edge after wr is registered.
    always @(posedge clk) begin
        if (bus.wr) rf[bus.wr_addr] <= bus.wr_data;
    end
    assign rd_a = rf[rd_addr_a];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.wr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_wr", 32'(bus.wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk("sb_data", 32'(bus.wr_data), 32'(e.data));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_clear();
        for (int a = 0; a < 8; a++) sb.push_back('{addr: 3'(a), data: 16'h0000});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr"},      32'(bus.wr),        32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr),   32'd0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data),   32'd0);
        chk({tag, "_busy"},    32'(bus.clr_busy),  32'd0);
        chk({tag, "_ready"},   32'(bus.req_ready), 32'd0);
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        reset = 1'b0;
        rd_addr_a = 3'd0;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.clr_start = 1'b0;

        // Power-up reset
        repeat (2) nxt();
        mid();
        chk_reset_outputs("por");
        nxt(); reset = 1'b1;

        // Activity, then reset asserted mid-run
        nxt();
        bus.req_valid = 2'b01; bus.req_addr = {3'd0, 3'd3}; bus.req_data = {16'h0, 16'h1234};
        sb.push_back('{addr: 3'd3, data: 16'h1234});
        mid(); chk("pre_ready", 32'(bus.req_ready), 32'h1);
        nxt(); bus.req_valid = '0;
        mid(); chk("pre_wr", 32'(bus.wr), 32'h1);
        #1 reset = 1'b0;
        #1 chk_reset_outputs("midrun");
        nxt(); reset = 1'b1;

        // Test 1: single request from requester 1
        nxt();
        bus.req_valid = 2'b10; bus.req_addr = {3'd5, 3'd0}; bus.req_data = {16'hBEEF, 16'h0};
        sb.push_back('{addr: 3'd5, data: 16'hBEEF});
        mid(); chk("t1_ready", 32'(bus.req_ready), 32'h2);
        nxt(); bus.req_valid = '0;
        mid();
        chk("t1_wr", 32'(bus.wr), 32'h1);
        chk("t1_wr_addr", 32'(bus.wr_addr), 32'h5);
        chk("t1_wr_data", 32'(bus.wr_data), 32'hBEEF);

        // Test 2: both requesters valid continuously -> alternate 0,1,0,1
        nxt();
        bus.req_valid = 2'b11; bus.req_addr = {3'd2, 3'd1}; bus.req_data = {16'h2222, 16'h1111};
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb.push_back('{addr: 3'd1, data: 16'h1111});
            else            sb.push_back('{addr: 3'd2, data: 16'h2222});
            mid();
            chk("t2_ready", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) begin
                chk("t2_wr", 32'(bus.wr), 32'h1);
                chk("t2_wr_addr", 32'(bus.wr_addr), (k % 2 == 1) ? 32'h1 : 32'h2);
            end
            nxt();
        end
        bus.req_valid = '0;
        mid();
        chk("t2_wr_last", 32'(bus.wr), 32'h1);
        chk("t2_wr_addr_last", 32'(bus.wr_addr), 32'h2);

        // Test 3: clr_start while req0 valid
        nxt();
        bus.clr_start = 1'b1;
        bus.req_valid = 2'b01; bus.req_addr = {3'd0, 3'd4}; bus.req_data = {16'h0, 16'h4444};
        push_clear();
        sb.push_back('{addr: 3'd4, data: 16'h4444});
        mid();
        chk("t3_ready_c0", 32'(bus.req_ready), 32'h0);
        chk("t3_busy_c0", 32'(bus.clr_busy), 32'h0);
        nxt(); bus.clr_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            mid();
            chk("t3_ready", 32'(bus.req_ready), 32'h0);
            chk("t3_busy", 32'(bus.clr_busy), 32'h1);
            if (c >= 2) begin
                chk("t3_clr_wr", 32'(bus.wr), 32'h1);
                chk("t3_clr_addr", 32'(bus.wr_addr), 32'(c - 2));
            end
            nxt();
        end
        mid();
        chk("t3_busy_c9", 32'(bus.clr_busy), 32'h0);
        chk("t3_ready_c9", 32'(bus.req_ready), 32'h1);
        chk("t3_clr_addr_c9", 32'(bus.wr_addr), 32'h7);
        nxt(); bus.req_valid = '0;
        mid();
        chk("t3_wr_c10", 32'(bus.wr), 32'h1);
        chk("t3_addr_c10", 32'(bus.wr_addr), 32'h4);

        // Test 4: second clr_start during CLEAR is ignored
        nxt(); bus.clr_start = 1'b1; push_clear();
        mid();
        for (int c = 1; c <= 8; c++) begin
            nxt(); bus.clr_start = (c == 3);
            mid(); chk("t4_busy", 32'(bus.clr_busy), 32'h1);
        end
        nxt(); bus.clr_start = 1'b0;
        mid(); chk("t4_busy_c9", 32'(bus.clr_busy), 32'h0);
        nxt();
        mid(); chk("t4_addr_c10", 32'(bus.wr_addr), 32'h7);
        nxt();
        mid(); chk("t4_wr_c11", 32'(bus.wr), 32'h0);

        // Test 5: reset at clear step 3, then rr_ptr restarts at 0
        nxt(); bus.clr_start = 1'b1; push_clear();
        for (int c = 1; c <= 5; c++) begin
            nxt(); bus.clr_start = 1'b0;
        end
        mid(); chk("t5_step3_addr", 32'(bus.wr_addr), 32'h3);
        #1 reset = 1'b0;
        sb.delete();
        #1 chk_reset_outputs("t5_rst");
        nxt(); reset = 1'b1;
        nxt();
        bus.req_valid = 2'b11; bus.req_addr = {3'd7, 3'd6}; bus.req_data = {16'h7777, 16'h6666};
        sb.push_back('{addr: 3'd6, data: 16'h6666});
        mid();
        chk("t5_busy", 32'(bus.clr_busy), 32'h0);
        chk("t5_ready", 32'(bus.req_ready), 32'h1);
        nxt(); bus.req_valid = '0;
        mid(); chk("t5_wr_addr", 32'(bus.wr_addr), 32'h6);

        // Test 6: end to end through the register file
        nxt();
        bus.req_valid = 2'b10; bus.req_addr = {3'd7, 3'd0}; bus.req_data = {16'hA5A5, 16'h0};
        sb.push_back('{addr: 3'd7, data: 16'hA5A5});
        rd_addr_a = 3'd7;
        mid(); chk("t6_ready", 32'(bus.req_ready), 32'h2);
        nxt(); bus.req_valid = '0;
        mid(); chk("t6_rd_acc_plus1", 32'(rd_a), 32'h0);
        nxt();
        mid(); chk("t6_rd_acc_plus2", 32'(rd_a), 32'hA5A5);
        nxt(); bus.clr_start = 1'b1; push_clear();
        nxt(); bus.clr_start = 1'b0;
        repeat (9) nxt();
        for (int a = 0; a < 8; a++) begin
            rd_addr_a = 3'(a);
            #1 chk("t6_rd_cleared", 32'(rd_a), 32'h0);
        end

        mid();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
